// File: rtl/cache_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_responder                                                 |
// | Purpose  : Responder end of the cache operation interface. Services        |
// |            READ/WRITE/FETCH/INVALIDATE/CLEAR requests from a direct-mapped,|
// |            write-back, write-allocate cache of one-word lines, with a      |
// |            backing-memory port for refills and dirty evictions, plus       |
// |            saturating hit/miss statistics.                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cache_responder #(
   parameter int WORD_W = 8,
   parameter int ADDR_W = 32,
   parameter int LINES  = 16,   // power of two, at least 2
   parameter int CNT_W  = 16
) (
   input  logic              clock_i,
   input  logic              reset_i,
   // request channel
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [3:0]        req_op_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [WORD_W-1:0] req_wdata_i,
   // response channel
   output logic              rsp_valid_o,
   output logic [WORD_W-1:0] rsp_data_o,
   output logic              rsp_hit_o,
   output logic              rsp_err_o,
   // backing-memory port
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [WORD_W-1:0] mem_rdata_i,
   // statistics
   output logic [CNT_W-1:0]  hit_count_o,
   output logic [CNT_W-1:0]  miss_count_o
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W;

   localparam logic [3:0] OP_READ  = 4'd0;
   localparam logic [3:0] OP_WRITE = 4'd1;
   localparam logic [3:0] OP_FETCH = 4'd2;
   localparam logic [3:0] OP_INVAL = 4'd3;
   localparam logic [3:0] OP_CLEAR = 4'd8;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOOKUP    = 3'd1,
      ST_WRITEBACK = 3'd2,
      ST_REFILL    = 3'd3,
      ST_RESPOND   = 3'd4
   } state_t;

   state_t state_q, state_d;

   // latched request
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;

   // cache storage; only valid/dirty need a reset value
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [WORD_W-1:0] data_q [LINES];
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;

   // registered response fields, presented only while in RESPOND
   logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_hit_q, rsp_hit_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_ld;

   logic [CNT_W-1:0]  hit_count_q, hit_count_d;
   logic [CNT_W-1:0]  miss_count_q, miss_count_d;

   // control strobes from the state machine
   logic              accept;
   logic              line_wr;       // install tag/data, set valid, load dirty
   logic [WORD_W-1:0] line_wr_data;
   logic              line_wr_dirty;
   logic              line_inval;    // clear valid/dirty of the indexed line
   logic              clear_all;     // clear every line and both counters
   logic              hit_inc;
   logic              miss_inc;

   // lookup of the indexed line
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  req_tag;
   logic [TAG_W-1:0]  line_tag;
   logic [WORD_W-1:0] line_data;
   logic              line_valid;
   logic              line_dirty;
   logic              lookup_hit;
   logic              victim_dirty;

   assign idx          = addr_q[IDX_W-1:0];
   assign req_tag      = addr_q[ADDR_W-1:IDX_W];
   assign line_tag     = tag_q[idx];
   assign line_data    = data_q[idx];
   assign line_valid   = valid_q[idx];
   assign line_dirty   = dirty_q[idx];
   assign lookup_hit   = line_valid && (line_tag == req_tag);
   assign victim_dirty = line_valid && line_dirty;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_READ, OP_WRITE, OP_FETCH, OP_INVAL, OP_CLEAR: op_legal = 1'b1;
         default:                                         op_legal = 1'b0;
      endcase
   endfunction

   // State register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and per-state control strobes.
   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      line_wr       = 1'b0;
      line_wr_data  = wdata_q;
      line_wr_dirty = 1'b0;
      line_inval    = 1'b0;
      clear_all     = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
      rsp_ld        = 1'b0;
      rsp_data_d    = '0;
      rsp_hit_d     = 1'b0;
      rsp_err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               accept = 1'b1;
               if (op_legal(req_op_i)) begin
                  state_d = ST_LOOKUP;
               end else begin
                  // illegal opcodes never touch the cache or the counters
                  rsp_ld    = 1'b1;
                  rsp_err_d = 1'b1;
                  state_d   = ST_RESPOND;
               end
            end
         end

         ST_LOOKUP: begin
            case (op_q)
               OP_READ, OP_FETCH: begin
                  if (lookup_hit) begin
                     hit_inc    = 1'b1;
                     rsp_ld     = 1'b1;
                     rsp_data_d = line_data;
                     rsp_hit_d  = 1'b1;
                     state_d    = ST_RESPOND;
                  end else begin
                     miss_inc = 1'b1;
                     state_d  = victim_dirty ? ST_WRITEBACK : ST_REFILL;
                  end
               end
               OP_WRITE: begin
                  if (lookup_hit) begin
                     hit_inc       = 1'b1;
                     line_wr       = 1'b1;
                     line_wr_dirty = 1'b1;
                     rsp_ld        = 1'b1;
                     rsp_hit_d     = 1'b1;
                     state_d       = ST_RESPOND;
                  end else if (victim_dirty) begin
                     miss_inc = 1'b1;
                     state_d  = ST_WRITEBACK;
                  end else begin
                     // one-word lines: a write miss allocates without a refill
                     miss_inc      = 1'b1;
                     line_wr       = 1'b1;
                     line_wr_dirty = 1'b1;
                     rsp_ld        = 1'b1;
                     state_d       = ST_RESPOND;
                  end
               end
               OP_INVAL: begin
                  if (lookup_hit && line_dirty) begin
                     state_d = ST_WRITEBACK;
                  end else begin
                     // a non-matching line belongs to another address and is kept
                     line_inval = lookup_hit;
                     rsp_ld     = 1'b1;
                     state_d    = ST_RESPOND;
                  end
               end
               OP_CLEAR: begin
                  clear_all = 1'b1;
                  rsp_ld    = 1'b1;
                  state_d   = ST_RESPOND;
               end
               default: begin
                  rsp_ld    = 1'b1;
                  rsp_err_d = 1'b1;
                  state_d   = ST_RESPOND;
               end
            endcase
         end

         ST_WRITEBACK: begin
            if (mem_ack_i) begin
               case (op_q)
                  OP_WRITE: begin
                     line_wr       = 1'b1;
                     line_wr_dirty = 1'b1;
                     rsp_ld        = 1'b1;
                     state_d       = ST_RESPOND;
                  end
                  OP_INVAL: begin
                     line_inval = 1'b1;
                     rsp_ld     = 1'b1;
                     state_d    = ST_RESPOND;
                  end
                  default: begin
                     state_d = ST_REFILL;
                  end
               endcase
            end
         end

         ST_REFILL: begin
            if (mem_ack_i) begin
               line_wr       = 1'b1;
               line_wr_data  = mem_rdata_i;
               line_wr_dirty = 1'b0;
               rsp_ld        = 1'b1;
               rsp_data_d    = mem_rdata_i;
               state_d       = ST_RESPOND;
            end
         end

         ST_RESPOND: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Capture the request on acceptance.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         op_q    <= req_op_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
      end
   end

   // Line state bits: reset and CLEAR wipe all lines without writebacks.
   always_ff @(posedge clock_i) begin
      if (reset_i || clear_all) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_wr) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= line_wr_dirty;
      end else if (line_inval) begin
         valid_q[idx] <= 1'b0;
         dirty_q[idx] <= 1'b0;
      end
   end

   // Tag and data arrays; contents are meaningless until the valid bit is set.
   always_ff @(posedge clock_i) begin
      if (line_wr) begin
         tag_q[idx]  <= req_tag;
         data_q[idx] <= line_wr_data;
      end
   end

   // Response fields are loaded on the transition into RESPOND.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rsp_data_q <= '0;
         rsp_hit_q  <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else if (rsp_ld) begin
         rsp_data_q <= rsp_data_d;
         rsp_hit_q  <= rsp_hit_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Saturating statistics; CLEAR zeroes them.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (clear_all) begin
         hit_count_d  = '0;
         miss_count_d = '0;
      end else begin
         if (hit_inc && (hit_count_q != CNT_MAX)) begin
            hit_count_d = hit_count_q + 1'b1;
         end
         if (miss_inc && (miss_count_q != CNT_MAX)) begin
            miss_count_d = miss_count_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   // Outputs are decoded from the state so every field is zero outside its phase.
   assign req_ready_o  = (state_q == ST_IDLE);
   assign rsp_valid_o  = (state_q == ST_RESPOND);
   assign rsp_data_o   = rsp_valid_o ? rsp_data_q : '0;
   assign rsp_hit_o    = rsp_valid_o & rsp_hit_q;
   assign rsp_err_o    = rsp_valid_o & rsp_err_q;

   assign mem_req_o    = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL);
   assign mem_we_o     = (state_q == ST_WRITEBACK);
   assign mem_addr_o   = (state_q == ST_WRITEBACK) ? {line_tag, idx} :
                         (state_q == ST_REFILL)    ? addr_q          : '0;
   assign mem_wdata_o  = (state_q == ST_WRITEBACK) ? line_data : '0;

   assign hit_count_o  = hit_count_q;
   assign miss_count_o = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_responder                                              |
// | Purpose  : Directed self-checking bench for cache_responder with a         |
// |            response scoreboard and a checking backing-memory model.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cache_responder;

   localparam int WORD_W = 8;
   localparam int ADDR_W = 32;
   localparam int LINES  = 16;
   localparam int CNT_W  = 4;
   localparam int MEM_D  = 2;   // extra wait cycles before each mem_ack

   localparam logic [3:0] OP_READ  = 4'd0;
   localparam logic [3:0] OP_WRITE = 4'd1;
   localparam logic [3:0] OP_FETCH = 4'd2;
   localparam logic [3:0] OP_INVAL = 4'd3;
   localparam logic [3:0] OP_CLEAR = 4'd8;
   localparam logic [3:0] OP_BAD   = 4'd5;

   logic              clk = 1'b0;
   logic              reset_i = 1'b1;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic [3:0]        req_op_i = '0;
   logic [ADDR_W-1:0] req_addr_i = '0;
   logic [WORD_W-1:0] req_wdata_i = '0;
   logic              rsp_valid_o;
   logic [WORD_W-1:0] rsp_data_o;
   logic              rsp_hit_o;
   logic              rsp_err_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [WORD_W-1:0] mem_wdata_o;
   logic              mem_ack_i = 1'b0;
   logic [WORD_W-1:0] mem_rdata_i = '0;
   logic [CNT_W-1:0]  hit_count_o;
   logic [CNT_W-1:0]  miss_count_o;

   cache_responder #(
      .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINES(LINES), .CNT_W(CNT_W)
   ) dut (
      .clock_i      (clk),
      .reset_i      (reset_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_hit_o    (rsp_hit_o),
      .rsp_err_o    (rsp_err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_ack_i    (mem_ack_i),
      .mem_rdata_i  (mem_rdata_i),
      .hit_count_o  (hit_count_o),
      .miss_count_o (miss_count_o)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       hit;
      logic       err;
      int         lat;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  wdata;
   } mem_t;

   rsp_t       rsp_q[$];
   mem_t       mem_q[$];
   logic [7:0] mem [logic [31:0]];
   rsp_t       mon_e;
   mem_t       mem_e;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int wait_cnt = 0;
   bit mon_en = 1'b0;
   bit mem_stall = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   // Response monitor: pops the scoreboard on every rsp_valid pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rsp_valid_o) begin
            chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
               mon_e = rsp_q.pop_front();
               chk("rsp_data", 32'(rsp_data_o), 32'(mon_e.data));
               chk("rsp_hit", 32'(rsp_hit_o), 32'(mon_e.hit));
               chk("rsp_err", 32'(rsp_err_o), 32'(mon_e.err));
               chk("rsp_latency", 32'(cyc - accept_cyc), 32'(mon_e.lat));
            end
         end else begin
            chk("rsp_idle_zero", 32'({rsp_data_o, rsp_hit_o, rsp_err_o}), 32'd0);
         end
      end
   end

   // Backing memory: acks each transaction after MEM_D+1 cycles and checks it.
   initial begin
      forever begin
         @(negedge clk);
         mem_ack_i = 1'b0;
         if (reset_i || mem_stall || !mem_req_o) begin
            wait_cnt = 0;
         end else if (wait_cnt < MEM_D) begin
            wait_cnt++;
         end else begin
            wait_cnt = 0;
            chk("mem_expected", 32'(mem_q.size() != 0), 32'd1);
            if (mem_q.size() != 0) begin
               mem_e = mem_q.pop_front();
               chk("mem_we", 32'(mem_we_o), 32'(mem_e.we));
               chk("mem_addr", mem_addr_o, mem_e.addr);
               if (mem_e.we) chk("mem_wdata", 32'(mem_wdata_o), 32'(mem_e.wdata));
            end
            if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : dflt(mem_addr_o);
            mem_ack_i = 1'b1;
         end
      end
   end

   task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [7:0] wd);
      mem_t m;
      m.we = we; m.addr = addr; m.wdata = wd;
      mem_q.push_back(m);
   endtask

   task automatic start_req(input logic [3:0] op, input logic [31:0] addr, input logic [7:0] wd);
      int n = 0;
      req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_wdata_i = wd;
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 32'(req_ready_o), 32'd1);
      accept_cyc = cyc;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_wdata_i = '0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [7:0] wd,
                        input logic [7:0] ed, input logic eh, input logic ee, input int lat);
      rsp_t e;
      int n = 0;
      e.data = ed; e.hit = eh; e.err = ee; e.lat = lat;
      rsp_q.push_back(e);
      start_req(op, addr, wd);
      while (rsp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_timeout", 32'(rsp_q.size()), 32'd0);
      rsp_q.delete();
   endtask

   task automatic cnt(input int h, input int m);
      chk("hit_count", 32'(hit_count_o), 32'(h));
      chk("miss_count", 32'(miss_count_o), 32'(m));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Directed sequence.
   initial begin
      int n;
      mem[32'h10] = 8'hAB;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_fields", 32'({rsp_data_o, rsp_hit_o, rsp_err_o}), 32'd0);
      chk("rst_mem_req", 32'({mem_req_o, mem_we_o}), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
      cnt(0, 0);
      mon_en = 1'b1;

      // cold miss then hit on 0x10
      exp_mem(1'b0, 32'h10, 8'h00);
      issue(OP_READ, 32'h10, 8'h00, 8'hAB, 1'b0, 1'b0, 5);
      cnt(0, 1);
      issue(OP_READ, 32'h10, 8'h00, 8'hAB, 1'b1, 1'b0, 2);
      cnt(1, 1);

      // write hit dirties the line; conflicting read forces writeback + refill
      issue(OP_WRITE, 32'h10, 8'h55, 8'h00, 1'b1, 1'b0, 2);
      cnt(2, 1);
      exp_mem(1'b1, 32'h10, 8'h55);
      exp_mem(1'b0, 32'h20, 8'h00);
      issue(OP_READ, 32'h20, 8'h00, 8'h7A, 1'b0, 1'b0, 8);
      cnt(2, 2);
      exp_mem(1'b0, 32'h10, 8'h00);
      issue(OP_READ, 32'h10, 8'h00, 8'h55, 1'b0, 1'b0, 5);
      cnt(2, 3);

      // clean write miss allocates without memory traffic
      issue(OP_WRITE, 32'h30, 8'h99, 8'h00, 1'b0, 1'b0, 2);
      cnt(2, 4);

      // invalidate a dirty line: one writeback, then the address misses
      exp_mem(1'b1, 32'h30, 8'h99);
      issue(OP_INVAL, 32'h30, 8'h00, 8'h00, 1'b0, 1'b0, 5);
      cnt(2, 4);
      exp_mem(1'b0, 32'h30, 8'h00);
      issue(OP_READ, 32'h30, 8'h00, 8'h99, 1'b0, 1'b0, 5);
      issue(OP_FETCH, 32'h30, 8'h00, 8'h99, 1'b1, 1'b0, 2);
      cnt(3, 5);

      // clean invalidate: no traffic, next access misses
      issue(OP_INVAL, 32'h30, 8'h00, 8'h00, 1'b0, 1'b0, 2);
      exp_mem(1'b0, 32'h30, 8'h00);
      issue(OP_READ, 32'h30, 8'h00, 8'h99, 1'b0, 1'b0, 5);
      cnt(3, 6);

      // illegal opcode
      issue(OP_BAD, 32'h30, 8'h00, 8'h00, 1'b0, 1'b1, 1);
      cnt(3, 6);

      // CLEAR drops a dirty line without writeback and zeroes the counters
      issue(OP_WRITE, 32'h44, 8'h12, 8'h00, 1'b0, 1'b0, 2);
      cnt(3, 7);
      issue(OP_CLEAR, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 2);
      cnt(0, 0);
      exp_mem(1'b0, 32'h44, 8'h00);
      issue(OP_READ, 32'h44, 8'h00, 8'h1E, 1'b0, 1'b0, 5);
      cnt(0, 1);

      // hit counter saturation at 2^CNT_W-1
      for (int i = 0; i < 14; i++) issue(OP_READ, 32'h44, 8'h00, 8'h1E, 1'b1, 1'b0, 2);
      cnt(14, 1);
      for (int i = 0; i < 6; i++) issue(OP_READ, 32'h44, 8'h00, 8'h1E, 1'b1, 1'b0, 2);
      cnt(15, 1);

      // reset while waiting for a refill
      mem_stall = 1'b1;
      start_req(OP_READ, 32'h50, 8'h00);
      n = 0;
      while (!mem_req_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("refill_req", 32'({mem_req_o, mem_we_o}), 32'd2);
      chk("refill_addr", mem_addr_o, 32'h50);
      repeat (2) @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      chk("abort_mem_req", 32'(mem_req_o), 32'd0);
      chk("abort_ready", 32'(req_ready_o), 32'd1);
      reset_i = 1'b0;
      mem_stall = 1'b0;
      repeat (4) @(negedge clk);
      cnt(0, 0);
      exp_mem(1'b0, 32'h44, 8'h00);
      issue(OP_READ, 32'h44, 8'h00, 8'h1E, 1'b0, 1'b0, 5);
      cnt(0, 1);

      repeat (3) @(negedge clk);
      chk("mem_pending", 32'(mem_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
